// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one command into an INCR burst on a 7-bit address bus.
// Define AHB_MASTER_TIMEOUT_EN to abort after TIMEOUT_CYCLES consecutive hready-low cycles.
module ahb_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [6:0]  cmd_count,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        error,
  output logic        hsel,
  output logic        hwrite,
  output logic [6:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR, S_DONE
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t      state_q, state_d;
  logic [6:0]  haddr_q;
  logic [6:0]  left_q;
  logic [1:0]  hsize_q;
  logic        hwrite_q;
  logic        dp_q;
  logic        err_q;
  logic        rdata_valid_q;
  logic [31:0] hwdata_q;
  logic [31:0] rdata_q;
  logic        addr_ok;
  logic        data_ok;
  logic        stall_wr;
  logic        to_hit;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;
  logic            bus_active;

  assign bus_active = (state_q == S_ADDR) || (state_q == S_BURST) ||
                      (state_q == S_LAST) || (state_q == S_ERR);
  assign to_hit = bus_active && !hready && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!n_rst || !bus_active || hready) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + TO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  assign stall_wr = hwrite_q && !wdata_valid;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    hsel      = 1'b0;
    htrans    = HT_IDLE;
    hburst    = 3'b000;
    done      = 1'b0;
    error     = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (cmd_count == 7'd0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        hsel   = 1'b1;
        hburst = 3'b001;
        if (!stall_wr) begin
          htrans = HT_NONSEQ;
          if (hready) begin
            addr_ok = 1'b1;
            state_d = (left_q == 7'd1) ? S_LAST : S_BURST;
          end
        end
      end
      S_BURST: begin
        hsel   = 1'b1;
        hburst = 3'b001;
        // First ERROR cycle cancels the pending address phase.
        if (dp_q && hresp && !hready) begin
          state_d = S_ERR;
        end else begin
          htrans = stall_wr ? HT_BUSY : HT_SEQ;
          if (hready) begin
            data_ok = dp_q;
            if (!stall_wr) begin
              addr_ok = 1'b1;
              if (left_q == 7'd1) begin
                state_d = S_LAST;
              end
            end
          end
        end
      end
      S_LAST: begin
        hsel = 1'b1;
        if (hresp && !hready) begin
          state_d = S_ERR;
        end else if (hready) begin
          data_ok = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ERR: begin
        hsel = 1'b1;
        if (hready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        error   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (to_hit) begin
      hsel    = 1'b0;
      htrans  = HT_IDLE;
      addr_ok = 1'b0;
      data_ok = 1'b0;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      haddr_q       <= '0;
      left_q        <= '0;
      hsize_q       <= '0;
      hwrite_q      <= 1'b0;
      dp_q          <= 1'b0;
      err_q         <= 1'b0;
      rdata_valid_q <= 1'b0;
      hwdata_q      <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      rdata_valid_q <= data_ok && !hwrite_q;
      if (hready) begin
        dp_q <= addr_ok;
      end
      if (cmd_valid && cmd_ready) begin
        haddr_q  <= cmd_addr;
        left_q   <= cmd_count;
        hsize_q  <= (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        hwrite_q <= cmd_write;
        dp_q     <= 1'b0;
        err_q    <= 1'b0;
      end
      if (addr_ok) begin
        haddr_q <= haddr_q + (7'd1 << hsize_q);
        left_q  <= left_q - 7'd1;
        if (hwrite_q) begin
          hwdata_q <= wdata;
        end
      end
      if (data_ok && !hwrite_q) begin
        rdata_q <= hrdata;
      end
      if (state_d == S_ERR || to_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wdata_ready = addr_ok && hwrite_q;
  assign haddr       = haddr_q;
  assign hsize       = hsize_q;
  assign hwrite      = hwrite_q;
  assign hwdata      = hwdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: bus phases, wait states, BUSY, ERROR, wrap, reset.
module tb_ahb_lite_master;

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [6:0]  cmd_count;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        error;
  logic        hsel;
  logic        hwrite;
  logic [6:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_count(cmd_count),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .error(error),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic s, input logic [1:0] t, input logic [6:0] a);
    chk1({tag, ".hsel"}, hsel, s);
    chk({tag, ".htrans"}, 32'(htrans), 32'(t));
    chk({tag, ".haddr"}, 32'(haddr), 32'(a));
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [6:0] a, input logic [1:0] s, input logic [6:0] c);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_count = c;
  endtask

  initial begin
    logic [6:0] ea;
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_count = '0; wdata = '0; wdata_valid = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    cyc(); cyc(); #1;
    chk1("rst.cmd_ready", cmd_ready, 1'b1);
    chk_bus("rst", 1'b0, 2'b00, 7'h00);
    chk("rst.hsize", 32'(hsize), 32'd0);
    chk("rst.hburst", 32'(hburst), 32'd0);
    chk1("rst.hwrite", hwrite, 1'b0);
    chk("rst.hwdata", hwdata, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk1("rst.rdata_valid", rdata_valid, 1'b0);
    chk1("rst.wdata_ready", wdata_ready, 1'b0);
    chk1("rst.done", done, 1'b0);
    chk1("rst.error", error, 1'b0);
    $display("txn reset checked");

    // Read 4 words from 0x00, zero wait states.
    cyc(); n_rst = 1'b1;
    issue(1'b0, 7'h00, 2'd2, 7'd4); #1;
    chk1("rd4.cmd_ready", cmd_ready, 1'b1);
    cyc(); cmd_valid = 1'b0; #1;
    chk_bus("rd4.b0", 1'b1, 2'b10, 7'h00);
    chk("rd4.hsize", 32'(hsize), 32'd2);
    chk("rd4.hburst", 32'(hburst), 32'd1);
    chk1("rd4.cmd_ready_busy", cmd_ready, 1'b0);
    for (int k = 1; k < 4; k++) begin
      cyc(); hrdata = 32'hA000_0000 + 32'(k - 1); #1;
      chk_bus("rd4.seq", 1'b1, 2'b11, 7'(4 * k));
      chk1("rd4.rvalid", rdata_valid, (k > 1));
      if (k > 1) chk("rd4.rdata", rdata, 32'hA000_0000 + 32'(k - 2));
    end
    cyc(); hrdata = 32'hA000_0003; #1;
    chk_bus("rd4.last", 1'b1, 2'b00, 7'h10);
    chk("rd4.rdata2", rdata, 32'hA000_0002);
    chk1("rd4.done_early", done, 1'b0);
    cyc(); #1;
    chk1("rd4.done", done, 1'b1);
    chk1("rd4.error", error, 1'b0);
    chk1("rd4.rvalid3", rdata_valid, 1'b1);
    chk("rd4.rdata3", rdata, 32'hA000_0003);
    chk("rd4.hburst_done", 32'(hburst), 32'd0);
    cyc(); #1;
    chk1("rd4.done_clr", done, 1'b0);
    chk1("rd4.rvalid_clr", rdata_valid, 1'b0);
    chk1("rd4.cmd_ready_back", cmd_ready, 1'b1);
    $display("txn read addr=00 size=2 count=4 done");

    // Write 3 words to 0x10 with the stream stalled before beat 2.
    issue(1'b1, 7'h10, 2'd2, 7'd3); wdata_valid = 1'b1; wdata = 32'h1111_0000; #1;
    chk1("wr3.wready_idle", wdata_ready, 1'b0);
    cyc(); cmd_valid = 1'b0; #1;
    chk_bus("wr3.b0", 1'b1, 2'b10, 7'h10);
    chk1("wr3.hwrite", hwrite, 1'b1);
    chk1("wr3.wready0", wdata_ready, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(); wdata_valid = 1'b0; #1;
      chk_bus("wr3.busy", 1'b1, 2'b01, 7'h14);
      chk1("wr3.wready_busy", wdata_ready, 1'b0);
      chk("wr3.hwdata0", hwdata, 32'h1111_0000);
    end
    cyc(); wdata_valid = 1'b1; wdata = 32'h2222_0001; #1;
    chk_bus("wr3.b1", 1'b1, 2'b11, 7'h14);
    chk1("wr3.wready1", wdata_ready, 1'b1);
    cyc(); wdata = 32'h3333_0002; #1;
    chk_bus("wr3.b2", 1'b1, 2'b11, 7'h18);
    chk1("wr3.wready2", wdata_ready, 1'b1);
    chk("wr3.hwdata1", hwdata, 32'h2222_0001);
    cyc(); wdata_valid = 1'b0; #1;
    chk_bus("wr3.last", 1'b1, 2'b00, 7'h1C);
    chk("wr3.hwdata2", hwdata, 32'h3333_0002);
    chk1("wr3.wready_last", wdata_ready, 1'b0);
    cyc(); #1;
    chk1("wr3.done", done, 1'b1);
    chk1("wr3.error", error, 1'b0);
    cyc();
    $display("txn write addr=10 size=2 count=3 done");

    // Read 3 words from 0x20, size 3 (treated as word), 3 wait states on beat 2 data phase.
    issue(1'b0, 7'h20, 2'd3, 7'd3);
    cyc(); cmd_valid = 1'b0; #1;
    chk_bus("rdw.b0", 1'b1, 2'b10, 7'h20);
    chk("rdw.hsize", 32'(hsize), 32'd2);
    cyc(); hrdata = 32'hB000_0000; #1;
    chk_bus("rdw.b1", 1'b1, 2'b11, 7'h24);
    for (int k = 0; k < 3; k++) begin
      cyc(); hready = 1'b0; hrdata = 32'hDEAD_BEEF; #1;
      chk_bus("rdw.wait", 1'b1, 2'b11, 7'h28);
      chk1("rdw.rvalid_wait", rdata_valid, (k == 0));
    end
    chk("rdw.rdata0", rdata, 32'hB000_0000);
    cyc(); hready = 1'b1; hrdata = 32'hB000_0001; #1;
    chk_bus("rdw.b2", 1'b1, 2'b11, 7'h28);
    chk1("rdw.done_early", done, 1'b0);
    cyc(); hrdata = 32'hB000_0002; #1;
    chk_bus("rdw.last", 1'b1, 2'b00, 7'h2C);
    chk("rdw.rdata1", rdata, 32'hB000_0001);
    chk1("rdw.rvalid1", rdata_valid, 1'b1);
    cyc(); #1;
    chk1("rdw.done", done, 1'b1);
    chk("rdw.rdata2", rdata, 32'hB000_0002);
    chk1("rdw.rvalid2", rdata_valid, 1'b1);
    cyc();
    $display("txn read addr=20 count=3 with 3 wait states done");

    // Write to 0x40 terminated by a two-cycle ERROR response.
    issue(1'b1, 7'h40, 2'd2, 7'd2); wdata_valid = 1'b1; wdata = 32'hC000_0000;
    cyc(); cmd_valid = 1'b0; #1;
    chk_bus("err.b0", 1'b1, 2'b10, 7'h40);
    chk1("err.wready0", wdata_ready, 1'b1);
    cyc(); wdata = 32'hC000_0001; hready = 1'b0; hresp = 1'b1; #1;
    chk_bus("err.cyc1", 1'b1, 2'b00, 7'h44);
    chk1("err.wready1", wdata_ready, 1'b0);
    chk("err.hwdata", hwdata, 32'hC000_0000);
    cyc(); hready = 1'b1; #1;
    chk("err.cyc2.htrans", 32'(htrans), 32'd0);
    chk1("err.cyc2.done", done, 1'b0);
    chk1("err.cyc2.wready", wdata_ready, 1'b0);
    cyc(); hresp = 1'b0; wdata_valid = 1'b0; #1;
    chk1("err.done", done, 1'b1);
    chk1("err.error", error, 1'b1);
    cyc(); #1;
    chk1("err.error_clr", error, 1'b0);
    chk1("err.cmd_ready", cmd_ready, 1'b1);
    $display("txn write addr=40 aborted by ERROR response");

    // Byte read from 0x7E wraps to 0x00.
    issue(1'b0, 7'h7E, 2'd0, 7'd3);
    for (int k = 0; k < 3; k++) begin
      cyc(); cmd_valid = 1'b0; hrdata = 32'h0000_00E0 + 32'(k); #1;
      ea = 7'h7E + 7'(k);
      chk_bus("wrap.beat", 1'b1, (k == 0) ? 2'b10 : 2'b11, ea);
      chk("wrap.hsize", 32'(hsize), 32'd0);
    end
    cyc(); hrdata = 32'h0000_00E3; #1;
    chk_bus("wrap.last", 1'b1, 2'b00, 7'h01);
    cyc(); #1;
    chk1("wrap.done", done, 1'b1);
    chk("wrap.rdata", rdata, 32'h0000_00E3);
    cyc();
    $display("txn byte read addr=7E count=3 done");

    // Zero-beat command: immediate done, bus untouched.
    issue(1'b0, 7'h30, 2'd2, 7'd0);
    cyc(); cmd_valid = 1'b0; #1;
    chk1("nop.done", done, 1'b1);
    chk1("nop.error", error, 1'b0);
    chk("nop.htrans", 32'(htrans), 32'd0);
    chk1("nop.hsel", hsel, 1'b0);
    cyc(); #1;
    chk1("nop.done_clr", done, 1'b0);
    chk1("nop.cmd_ready", cmd_ready, 1'b1);
    $display("txn count=0 no-op done");

    // Reset in the middle of a burst: back to idle, no done pulse.
    issue(1'b0, 7'h00, 2'd2, 7'd4);
    cyc(); cmd_valid = 1'b0;
    cyc(); n_rst = 1'b0; #1;
    chk_bus("mrst.pre", 1'b1, 2'b11, 7'h04);
    cyc(); n_rst = 1'b1; #1;
    chk_bus("mrst.post", 1'b0, 2'b00, 7'h00);
    chk1("mrst.cmd_ready", cmd_ready, 1'b1);
    chk1("mrst.done", done, 1'b0);
    cyc(); #1;
    chk1("mrst.done_after", done, 1'b0);
    $display("txn reset mid-burst checked");

`ifdef AHB_MASTER_TIMEOUT_EN
    // hready stuck low: abort on the 16th low cycle, done+error next.
    issue(1'b0, 7'h08, 2'd2, 7'd1);
    cyc(); cmd_valid = 1'b0; hready = 1'b0; #1;
    chk_bus("to.b0", 1'b1, 2'b10, 7'h08);
    for (int k = 2; k < 16; k++) begin
      cyc();
    end
    #1;
    chk1("to.hold.hsel", hsel, 1'b1);
    chk1("to.hold.done", done, 1'b0);
    cyc(); #1;
    chk_bus("to.abort", 1'b0, 2'b00, 7'h08);
    chk1("to.abort.done", done, 1'b0);
    cyc(); #1;
    chk1("to.done", done, 1'b1);
    chk1("to.error", error, 1'b1);
    hready = 1'b1;
    cyc();
    $display("txn timeout abort checked");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
